line_drive_ctrl: RTL and testbench
==================================

# line_drive_ctrl

Parametrised line-following drive controller for the car: fuses an N-sensor tracker array and the ultrasonic stop flag into a registered steering state, and generates per-wheel PWM duty and H-bridge direction bits. It sits between the sensor front-ends (tracker, sonic) and the motor driver pins. It supersedes the fixed 3-sensor, on/off steering path. It adds weighted line-error steering, differential-speed turns, lost-line search with timeout, and period-aligned updates.

## Interface
- N_SENS, 5: tracker sensors, 3..8; index 0 = leftmost.
- PWM_W, 8: PWM counter/duty width; period = 2^PWM_W cycles.
- SPEED_FAST, 200: duty for straight and outer wheel of a soft turn.
- SPEED_TURN, 120: inner-wheel duty in a soft turn.
- SPEED_SHARP, 150: duty of both wheels in a pivot or search.
- SHARP_TH, 4: |error| ≥ SHARP_TH selects a pivot turn.
- LOST_PERIODS, 64: PWM periods in SEARCH before STOP.
- RAMP_STEP, 16: duty step per period (soft-start only).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  drive enable; 0 forces IDLE
- sens  in  N_SENS  raw tracker inputs, 1 = line seen
- obstacle  in  1  stop request from the sonic block
- pwm_l, pwm_r  out  1  wheel PWM
- dir_l, dir_r  out  2  10 forward, 01 reverse, 00 brake
- state  out  3  current steering state (package encoding)
- lost  out  1  sticky: search timed out

## Operation
- sens passes through a 2-flop synchroniser per bit.
- Error e = Σ sens[i]·(2i − (N_SENS−1)), signed, width $clog2(N_SENS²)+2; no overflow is possible.
- Classification: sens==0 → SEARCH; e==0 → STRAIGHT; e<0 and |e|<SHARP_TH → TURN_L; e≤−SHARP_TH → SHARP_L; the positive cases mirror to TURN_R/SHARP_R.
- States: IDLE, STRAIGHT, TURN_L, TURN_R, SHARP_L, SHARP_R, SEARCH, STOP.
- Per-state outputs:
  - STRAIGHT: dir 10/10, duty FAST/FAST.
  - TURN_L: dir 10/10, duty TURN/FAST. TURN_R mirrors.
  - SHARP_L: dir 01/10, duty SHARP/SHARP. SHARP_R mirrors.
  - SEARCH: pivots toward last_side at SHARP duty.
  - IDLE and STOP: dir 00/00, duty 0.
- last_side: updated on entry to any TURN or SHARP state; reset value is left.
- SEARCH counts whole periods. Re-acquiring the line resets the count and reclassifies. Reaching LOST_PERIODS → STOP, lost=1.
- STOP with lost=1 is held until rst or en=0.
- obstacle=1 forces STOP; the lost flag is unaffected. Obstacle release → reclassify at the next period boundary.
- en=0 → IDLE, clears lost and the search count. IDLE → classification at the first boundary with en=1 and obstacle=0.

## Timing
- PWM counter runs free 0..2^PWM_W−1. pwm_x = (cnt < duty_x), registered. duty=0 gives constant low; duty is never 100 %.
- Steering state, dir and duty update only on the cycle cnt wraps to 0, which is a glitch-free period boundary.
- Exceptions take effect 1 cycle after being sampled, regardless of cnt, overriding everything else:
  - obstacle=1 → STOP; pwm and dir forced low/00 the next cycle.
  - en=0 → IDLE.
- Sensor-to-state latency: 2 sync cycles, plus the wait to the next boundary (≤2^PWM_W), plus 1 cycle.
- Reset values:
  - state=IDLE, dir_l=dir_r=00, pwm_l=pwm_r=0, lost=0, cnt=0, duties 0, last_side=left.
- rst mid-period: everything returns to reset values the next cycle; there is no partial period.
- obstacle and en=0 together: IDLE wins.

## Configuration
- LINE_DRIVE_SOFTSTART_EN defined:
  - each period boundary moves each applied duty toward its target by at most RAMP_STEP, saturating at the target;
  - direction reversals first ramp to 0, then flip dir;
  - STOP and IDLE still cut to 0 immediately.
- Undefined: applied duty equals target at each boundary.

## Structure
- line_drive_pkg holds:
  - the state enum (3-bit: IDLE=0, STRAIGHT=1, TURN_L=2, TURN_R=3, SHARP_L=4, SHARP_R=5, SEARCH=6, STOP=7);
  - the DIR_FWD/DIR_REV/DIR_BRK constants;
  - the error-width function.
- One sub-module, drive_pwm_gen: counter, wrap strobe, two comparators, plus the optional ramp.
- The parent keeps the sync, classifier and FSM.

## Test plan
- N_SENS=5, sens=00100 held, rst released → after the first boundary: state STRAIGHT, dir 10/10, pwm_l and pwm_r high for 200 of 256 cycles.
- sens 00100→00010 mid-period → state stays STRAIGHT until the wrap, then TURN_L, duty 120/200.
- sens=00001 → SHARP_L, dir_l=01, dir_r=10, both duties 150.
- sens=00000 after SHARP_R → SEARCH pivoting right. After 64 periods: STOP, lost=1. sens=00100 then does not resume. en pulse low → IDLE, lost=0.
- obstacle asserted at cnt=37 → cycle 38: dir 00/00, pwm 0. Release → resume at the next wrap. obstacle with en=0 → IDLE.
- With LINE_DRIVE_SOFTSTART_EN, STRAIGHT from IDLE → duties 16, 32, … 192, 200 across successive periods. SHARP_L from STRAIGHT → left duty ramps to 0 before dir_l becomes 01.

Source files
------------

// File: rtl/line_drive_ctrl_pkg.sv
// Shared types for the line-following drive controller: steering state
// encoding, H-bridge direction codes and the line-error width helper.
package line_drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STRAIGHT = 3'd1,
    ST_TURN_L   = 3'd2,
    ST_TURN_R   = 3'd3,
    ST_SHARP_L  = 3'd4,
    ST_SHARP_R  = 3'd5,
    ST_SEARCH   = 3'd6,
    ST_STOP     = 3'd7
  } state_e;

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_BRK = 2'b00;

  // Signed width that holds any weighted sum of n sensors without overflow.
  function automatic int err_w(input int n);
    return $clog2(n * n) + 2;
  endfunction

endpackage

// File: rtl/line_drive_ctrl_if.sv
// Sensor-side inputs and motor-side outputs of the drive controller.
interface line_drive_ctrl_if #(
  parameter int N_SENS = 5
);
  logic              en;
  logic [N_SENS-1:0] sens;
  logic              obstacle;
  logic              pwm_l;
  logic              pwm_r;
  logic [1:0]        dir_l;
  logic [1:0]        dir_r;
  logic [2:0]        state;
  logic              lost;

  modport master (output en, sens, obstacle,
                  input  pwm_l, pwm_r, dir_l, dir_r, state, lost);
  modport slave  (input  en, sens, obstacle,
                  output pwm_l, pwm_r, dir_l, dir_r, state, lost);
endinterface

// File: rtl/line_drive_ctrl_drive_pwm_gen.sv
// Free-running PWM counter, period-wrap strobe and per-wheel duty/dir regs.
// LINE_DRIVE_SOFTSTART_EN enables the per-period duty ramp.
module drive_pwm_gen
  import line_drive_pkg::*;
#(
  parameter int PWM_W     = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_kill,
  input  logic                  i_cut,
  input  logic [1:0][PWM_W-1:0] i_tgt_duty,
  input  logic [1:0][1:0]       i_tgt_dir,
  output logic                  o_wrap,
  output logic [1:0]            o_pwm,
  output logic [1:0][1:0]       o_dir
);

`ifdef LINE_DRIVE_SOFTSTART_EN
  localparam int STEP = RAMP_STEP;
  localparam bit SOFT = 1'b1;
`else
  // A step wider than the duty range makes every ramp land on target at once.
  localparam int STEP = RAMP_STEP + (1 << PWM_W);
  localparam bit SOFT = 1'b0;
`endif

  logic [PWM_W-1:0]            r_cnt;
  logic [PWM_W-1:0]            w_cnt_nxt;
  logic [1:0][PWM_W-1:0]       r_duty;
  logic [1:0][PWM_W-1:0]       w_duty_nxt;
  logic [1:0][1:0]             r_dir;
  logic [1:0][1:0]             w_dir_nxt;
  logic [1:0]                  r_pwm;

  function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] cur,
                                            input logic [PWM_W-1:0] tgt);
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
    if (t > c + STEP) return PWM_W'(c + STEP);
    if (t < c - STEP) return PWM_W'(c - STEP);
    return tgt;
  endfunction

  assign o_wrap    = (r_cnt == '1);
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_comb begin
    w_duty_nxt = r_duty;
    w_dir_nxt  = r_dir;
    for (int w = 0; w < 2; w++) begin
      if (i_kill || (o_wrap && i_cut)) begin
        w_duty_nxt[w] = '0;
        w_dir_nxt[w]  = DIR_BRK;
      end else if (o_wrap) begin
        // A reversal first bleeds the wheel down to zero under the old dir.
        if (SOFT && (r_dir[w] != i_tgt_dir[w]) && (r_duty[w] != '0)) begin
          w_duty_nxt[w] = ramp(r_duty[w], '0);
        end else begin
          w_dir_nxt[w]  = i_tgt_dir[w];
          w_duty_nxt[w] = ramp(r_duty[w], i_tgt_duty[w]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_dir  <= '0;
      r_pwm  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_duty <= w_duty_nxt;
      r_dir  <= w_dir_nxt;
      for (int w = 0; w < 2; w++) r_pwm[w] <= (w_cnt_nxt < w_duty_nxt[w]);
    end
  end

  assign o_pwm = r_pwm;
  assign o_dir = r_dir;

endmodule

// File: rtl/line_drive_ctrl.sv
// Line-following drive controller: sensor sync, line-error classifier and
// steering FSM feeding drive_pwm_gen (soft-start via LINE_DRIVE_SOFTSTART_EN).
module line_drive_ctrl
  import line_drive_pkg::*;
#(
  parameter int N_SENS       = 5,
  parameter int PWM_W        = 8,
  parameter int SPEED_FAST   = 200,
  parameter int SPEED_TURN   = 120,
  parameter int SPEED_SHARP  = 150,
  parameter int SHARP_TH     = 4,
  parameter int LOST_PERIODS = 64,
  parameter int RAMP_STEP    = 16
) (
  input  logic               clk,
  input  logic               rst,
  line_drive_ctrl_if.slave   bus
);

  localparam int EW = err_w(N_SENS);
  localparam int LW = $clog2(LOST_PERIODS + 1);
  localparam logic signed [EW-1:0] TH = EW'(SHARP_TH);
  localparam logic [PWM_W-1:0] D_FAST  = PWM_W'(SPEED_FAST);
  localparam logic [PWM_W-1:0] D_TURN  = PWM_W'(SPEED_TURN);
  localparam logic [PWM_W-1:0] D_SHARP = PWM_W'(SPEED_SHARP);

  logic [N_SENS-1:0]     r_s1, r_s2;
  logic signed [EW-1:0]  w_err;
  state_e                w_cls;
  state_e                r_state, w_nxt;
  logic                  r_lost, w_lost_nxt;
  logic [LW-1:0]         r_scnt, w_scnt_nxt;
  logic                  r_side, w_side_nxt;  // 0 = left, 1 = right
  logic                  w_wrap, w_kill, w_cut;
  logic [1:0][PWM_W-1:0] w_tgt_duty;
  logic [1:0][1:0]       w_tgt_dir;
  logic [1:0]            w_pwm;
  logic [1:0][1:0]       w_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.sens;
      r_s2 <= r_s1;
    end
  end

  // Sensor i weighs 2i-(N-1): negative means the line sits left of centre.
  always_comb begin
    w_err = '0;
    for (int i = 0; i < N_SENS; i++)
      if (r_s2[i]) w_err = w_err + EW'(2 * i - (N_SENS - 1));
  end

  always_comb begin
    w_cls = ST_STRAIGHT;
    if (r_s2 == '0)        w_cls = ST_SEARCH;
    else if (w_err <= -TH) w_cls = ST_SHARP_L;
    else if (w_err[EW-1])  w_cls = ST_TURN_L;
    else if (w_err >= TH)  w_cls = ST_SHARP_R;
    else if (w_err != '0)  w_cls = ST_TURN_R;
  end

  always_comb begin
    w_nxt      = r_state;
    w_lost_nxt = r_lost;
    w_scnt_nxt = r_scnt;
    w_side_nxt = r_side;
    if (!bus.en) begin
      w_nxt      = ST_IDLE;
      w_lost_nxt = 1'b0;
      w_scnt_nxt = '0;
    end else if (bus.obstacle) begin
      w_nxt = ST_STOP;
    end else if (w_wrap && !(r_state == ST_STOP && r_lost)) begin
      w_nxt      = w_cls;
      w_scnt_nxt = '0;
      if (w_cls == ST_SEARCH && r_state == ST_SEARCH) begin
        if (r_scnt == LW'(LOST_PERIODS - 1)) begin
          w_nxt      = ST_STOP;
          w_lost_nxt = 1'b1;
        end else begin
          w_scnt_nxt = r_scnt + 1'b1;
        end
      end
      if (w_nxt == ST_TURN_L || w_nxt == ST_SHARP_L) w_side_nxt = 1'b0;
      if (w_nxt == ST_TURN_R || w_nxt == ST_SHARP_R) w_side_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lost  <= 1'b0;
      r_scnt  <= '0;
      r_side  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_lost  <= w_lost_nxt;
      r_scnt  <= w_scnt_nxt;
      r_side  <= w_side_nxt;
    end
  end

  // Targets follow the state being loaded so duty and state change together.
  always_comb begin
    w_tgt_dir  = {DIR_BRK, DIR_BRK};
    w_tgt_duty = '0;
    unique case (w_nxt)
      ST_STRAIGHT: begin w_tgt_dir = {DIR_FWD, DIR_FWD}; w_tgt_duty = {D_FAST, D_FAST};   end
      ST_TURN_L:   begin w_tgt_dir = {DIR_FWD, DIR_FWD}; w_tgt_duty = {D_FAST, D_TURN};   end
      ST_TURN_R:   begin w_tgt_dir = {DIR_FWD, DIR_FWD}; w_tgt_duty = {D_TURN, D_FAST};   end
      ST_SHARP_L:  begin w_tgt_dir = {DIR_FWD, DIR_REV}; w_tgt_duty = {D_SHARP, D_SHARP}; end
      ST_SHARP_R:  begin w_tgt_dir = {DIR_REV, DIR_FWD}; w_tgt_duty = {D_SHARP, D_SHARP}; end
      ST_SEARCH: begin
        w_tgt_dir  = w_side_nxt ? {DIR_REV, DIR_FWD} : {DIR_FWD, DIR_REV};
        w_tgt_duty = {D_SHARP, D_SHARP};
      end
      default: ;
    endcase
  end

  assign w_kill = !bus.en || bus.obstacle;
  assign w_cut  = (w_nxt == ST_IDLE) || (w_nxt == ST_STOP);

  drive_pwm_gen #(
    .PWM_W     (PWM_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .i_kill     (w_kill),
    .i_cut      (w_cut),
    .i_tgt_duty (w_tgt_duty),
    .i_tgt_dir  (w_tgt_dir),
    .o_wrap     (w_wrap),
    .o_pwm      (w_pwm),
    .o_dir      (w_dir)
  );

  assign bus.pwm_l = w_pwm[0];
  assign bus.pwm_r = w_pwm[1];
  assign bus.dir_l = w_dir[0];
  assign bus.dir_r = w_dir[1];
  assign bus.state = r_state;
  assign bus.lost  = r_lost;

endmodule

// File: tb/tb_line_drive_ctrl.sv
// Scoreboard bench for line_drive_ctrl: a cycle-level reference model pushes
// expected outputs each clock, a negedge monitor pops and compares.
module tb_line_drive_ctrl;
  import line_drive_pkg::*;

  localparam int N     = 5;
  localparam int PW    = 8;
  localparam int P     = 1 << PW;
  localparam int FAST  = 200;
  localparam int TURN  = 120;
  localparam int SHARP = 150;
  localparam int TH    = 4;
  localparam int LOSTP = 64;
  localparam int STEP  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_drive_ctrl_if #(.N_SENS(N)) bus();

  line_drive_ctrl #(
    .N_SENS(N), .PWM_W(PW), .SPEED_FAST(FAST), .SPEED_TURN(TURN),
    .SPEED_SHARP(SHARP), .SHARP_TH(TH), .LOST_PERIODS(LOSTP), .RAMP_STEP(STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] st;
    logic [1:0] dl, dr;
    logic       pl, pr, lost;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  state_e      m_st;
  logic        m_lost, m_side;
  int          m_scnt, m_cnt, m_ul, m_ur;
  logic [1:0]  m_dl, m_dr;
  logic [N-1:0] m_s1, m_s2;

  function automatic void tgt(input state_e st, input logic side,
                              output logic [1:0] dl, output logic [1:0] dr,
                              output int tl, output int tr);
    dl = DIR_BRK; dr = DIR_BRK; tl = 0; tr = 0;
    case (st)
      ST_STRAIGHT: begin dl = DIR_FWD; dr = DIR_FWD; tl = FAST;  tr = FAST;  end
      ST_TURN_L:   begin dl = DIR_FWD; dr = DIR_FWD; tl = TURN;  tr = FAST;  end
      ST_TURN_R:   begin dl = DIR_FWD; dr = DIR_FWD; tl = FAST;  tr = TURN;  end
      ST_SHARP_L:  begin dl = DIR_REV; dr = DIR_FWD; tl = SHARP; tr = SHARP; end
      ST_SHARP_R:  begin dl = DIR_FWD; dr = DIR_REV; tl = SHARP; tr = SHARP; end
      ST_SEARCH: begin
        if (side) begin dl = DIR_FWD; dr = DIR_REV; end
        else      begin dl = DIR_REV; dr = DIR_FWD; end
        tl = SHARP; tr = SHARP;
      end
      default: ;
    endcase
  endfunction

`ifdef LINE_DRIVE_SOFTSTART_EN
  task automatic ramp_wheel(inout logic [1:0] d, inout int u,
                            input logic [1:0] td, input int tu);
    if (d != td && u != 0) begin
      u = (u > STEP) ? u - STEP : 0;
    end else begin
      d = td;
      if (tu > u + STEP)      u = u + STEP;
      else if (tu < u - STEP) u = u - STEP;
      else                    u = tu;
    end
  endtask
`endif

  // Reference model: evaluated on each rising edge with the inputs the DUT samples.
  always @(posedge clk) begin
    exp_t e;
    int err;
    logic [1:0] tdl, tdr;
    int ttl, ttr;
    if (rst) begin
      m_st = ST_IDLE; m_lost = 0; m_side = 0; m_scnt = 0; m_cnt = 0;
      m_ul = 0; m_ur = 0; m_dl = DIR_BRK; m_dr = DIR_BRK; m_s1 = '0; m_s2 = '0;
    end else begin
      if (!bus.en) begin
        m_st = ST_IDLE; m_lost = 0; m_scnt = 0;
        m_ul = 0; m_ur = 0; m_dl = DIR_BRK; m_dr = DIR_BRK;
      end else if (bus.obstacle) begin
        m_st = ST_STOP;
        m_ul = 0; m_ur = 0; m_dl = DIR_BRK; m_dr = DIR_BRK;
      end else if (m_cnt == P - 1) begin
        if (!(m_st == ST_STOP && m_lost)) begin
          err = 0;
          for (int i = 0; i < N; i++) if (m_s2[i]) err += 2 * i - (N - 1);
          if (m_s2 == '0) begin
            if (m_st == ST_SEARCH) begin
              m_scnt++;
              if (m_scnt >= LOSTP) begin m_st = ST_STOP; m_lost = 1; end
            end else begin
              m_st = ST_SEARCH; m_scnt = 0;
            end
          end else begin
            m_scnt = 0;
            if (err == 0)        m_st = ST_STRAIGHT;
            else if (err <= -TH) begin m_st = ST_SHARP_L; m_side = 0; end
            else if (err < 0)    begin m_st = ST_TURN_L;  m_side = 0; end
            else if (err >= TH)  begin m_st = ST_SHARP_R; m_side = 1; end
            else                 begin m_st = ST_TURN_R;  m_side = 1; end
          end
        end
        tgt(m_st, m_side, tdl, tdr, ttl, ttr);
`ifdef LINE_DRIVE_SOFTSTART_EN
        if (m_st == ST_IDLE || m_st == ST_STOP) begin
          m_ul = 0; m_ur = 0; m_dl = DIR_BRK; m_dr = DIR_BRK;
        end else begin
          ramp_wheel(m_dl, m_ul, tdl, ttl);
          ramp_wheel(m_dr, m_ur, tdr, ttr);
        end
`else
        m_dl = tdl; m_dr = tdr; m_ul = ttl; m_ur = ttr;
`endif
      end
      m_cnt = (m_cnt + 1) % P;
      m_s2  = m_s1;
      m_s1  = bus.sens;
    end
    e.st = m_st; e.dl = m_dl; e.dr = m_dr; e.lost = m_lost;
    e.pl = (m_cnt < m_ul);
    e.pr = (m_cnt < m_ur);
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty t=%0t no expected entry for this cycle", $time);
    end else begin
      e = q.pop_front();
      if (bus.state !== e.st || bus.dir_l !== e.dl || bus.dir_r !== e.dr ||
          bus.pwm_l !== e.pl || bus.pwm_r !== e.pr || bus.lost !== e.lost) begin
        errors++;
        $display("FAIL outputs t=%0t got st=%0d dir=%b/%b pwm=%b/%b lost=%b want st=%0d dir=%b/%b pwm=%b/%b lost=%b",
                 $time, bus.state, bus.dir_l, bus.dir_r, bus.pwm_l, bus.pwm_r, bus.lost,
                 e.st, e.dl, e.dr, e.pl, e.pr, e.lost);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    int n;
    bus.en = 1'b1; bus.obstacle = 1'b0; bus.sens = 5'b00100;
    cyc(3);
    rst = 1'b0;
    cyc(2 * P + 20);                       // STRAIGHT at 200/200
    bus.sens = 5'b00010; cyc(2 * P);       // mid-period change -> TURN_L
    bus.sens = 5'b00001; cyc(2 * P + 7);   // SHARP_L
    bus.sens = 5'b10000; cyc(P + 30);      // SHARP_R
    bus.sens = 5'b00000; cyc((LOSTP + 3) * P);  // SEARCH right -> STOP lost
    bus.sens = 5'b00100; cyc(2 * P);       // lost STOP holds
    bus.en = 1'b0; cyc(3); bus.en = 1'b1;  // clears lost, IDLE
    cyc(2 * P);
    n = 0;
    while (m_cnt != 37 && n < 2 * P) begin cyc(1); n++; end
    if (m_cnt != 37) begin
      checks++; errors++;
      $display("FAIL align_cnt37 got cnt=%0d want 37", m_cnt);
    end
    bus.obstacle = 1'b1; cyc(100);
    bus.obstacle = 1'b0; cyc(2 * P);
    bus.obstacle = 1'b1; bus.en = 1'b0; cyc(10);
    bus.obstacle = 1'b0; bus.en = 1'b1; cyc(2 * P);

    for (int k = 0; k < 100; k++) begin
      r = $urandom_range(0, 29);
      if (r == 0) begin
        rst = 1'b1; cyc($urandom_range(1, 4)); rst = 1'b0;
      end else if (r < 3) begin
        bus.en = 1'b0; cyc($urandom_range(1, 20)); bus.en = 1'b1;
      end else if (r < 6) begin
        bus.obstacle = 1'b1; cyc($urandom_range(1, 300)); bus.obstacle = 1'b0;
      end else if (r == 6) begin
        bus.obstacle = 1'b1; bus.en = 1'b0; cyc($urandom_range(1, 10));
        bus.obstacle = 1'b0; bus.en = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) bus.sens = '0;
      else                           bus.sens = 5'($urandom_range(1, (1 << N) - 1));
      cyc($urandom_range(20, 600));
    end
    cyc(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
